// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: widths, opcodes, fetch state encoding, entry layout.
// ST_HALTED is present only when FETCH_HALT_ON_EBREAK_EN is defined.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;
  localparam int FETCH_ENTRY_W = 2 * XLEN;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1
`ifdef FETCH_HALT_ON_EBREAK_EN
    , ST_HALTED = 2'd2
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect request, decode handshake, status.
// master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            fetch_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic            misalign_fault;
  logic            halted;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    output imem_addr, id_valid, id_pc, id_instr, misalign_fault, halted
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    input  imem_addr, id_valid, id_pc, id_instr, misalign_fault, halted
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush; the head entry is read straight from the
// storage registers and forced to zero while the buffer is empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W + 1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, buffers {pc, instr} for decode, handles redirects.
// EBREAK halting is built only with FETCH_HALT_ON_EBREAK_EN.
//   state     | meaning
//   ST_RUN    | fetching, one word per cycle while the buffer has room
//   ST_FAULT  | last redirect target misaligned; no fetch until aligned redirect
//   ST_HALTED | EBREAK fetched; buffer drains, no fetch until redirect
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  fetch_entry_t    tail;
  fetch_entry_t    head;

  assign tail = '{pc: pc, instr: bus.imem_instr};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (tail),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect discards everything in flight, including this cycle's push/pop.
      flush    = 1'b1;
      pc_nx    = bus.redirect_pc;
      state_nx = is_aligned(bus.redirect_pc[1:0]) ? ST_RUN : ST_FAULT;
    end else begin
      pop = !empty && bus.id_ready;
      if (state == ST_RUN && bus.fetch_en && (!full || pop)) begin
        push = 1'b1;
`ifdef FETCH_HALT_ON_EBREAK_EN
        if (bus.imem_instr == INSTR_EBREAK) state_nx = ST_HALTED;
        else                                pc_nx    = pc + 32'd4;
`else
        pc_nx = pc + 32'd4;
`endif
      end
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.id_valid       = !empty;
  assign bus.id_pc          = head.pc;
  assign bus.id_instr       = head.instr;
  assign bus.misalign_fault = (state == ST_FAULT);
`ifdef FETCH_HALT_ON_EBREAK_EN
  assign bus.halted         = (state == ST_HALTED);
`else
  assign bus.halted         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random traffic against a queue-based model.
// The EBREAK halt section runs only when FETCH_HALT_ON_EBREAK_EN is defined.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  logic ebreak_at_8 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_halt;

  logic [31:0] tgts[8] = '{32'h0, 32'h4, 32'h10, 32'h3C, 32'h6, 32'h1, 32'hFFFF_FFFC, 32'h100};

  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus2();

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset), .bus(bus2));

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic eb);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return eb ? 32'h0010_0073 : 32'h0020_0113;
      32'hC:   return 32'h0030_8193;
      default: return {a[26:2], 7'h13};
    endcase
  endfunction

  always_comb bus.imem_instr  = mem_word(bus.imem_addr, ebreak_at_8);
  always_comb bus2.imem_instr = mem_word(bus2.imem_addr, 1'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = RST_PC;
    m_fault = 0;
    m_halt  = 0;
  endtask

  // Applies the fetch rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          pop;
    bit          fetch;
    logic [31:0] w;
    if (reset) begin
      model_reset();
    end else if (bus.redirect_valid) begin
      m_q.delete();
      m_pc    = bus.redirect_pc;
      m_fault = (bus.redirect_pc[1:0] != 2'b00);
      m_halt  = 0;
    end else begin
      pop   = (m_q.size() != 0) && bus.id_ready;
      fetch = !m_fault && !m_halt && bus.fetch_en && (m_q.size() < DEPTH || pop);
      w     = mem_word(m_pc, ebreak_at_8);
      if (pop) void'(m_q.pop_front());
      if (fetch) begin
        m_q.push_back({m_pc, w});
`ifdef FETCH_HALT_ON_EBREAK_EN
        if (w == 32'h0010_0073) m_halt = 1;
        else                    m_pc = m_pc + 32'd4;
`else
        m_pc = m_pc + 32'd4;
`endif
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("id_valid", {31'b0, bus.id_valid}, {31'b0, m_q.size() != 0});
    chk("id_pc", bus.id_pc, h[63:32]);
    chk("id_instr", bus.id_instr, h[31:0]);
    chk("misalign_fault", {31'b0, bus.misalign_fault}, {31'b0, m_fault});
    chk("halted", {31'b0, bus.halted}, {31'b0, m_halt});
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_en = 1'b0; bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus2.fetch_en = 1'b1; bus2.id_ready = 1'b1;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0;
    model_reset();
    @(posedge clk); #1;
    check_model();
    chk("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_valid", {31'b0, bus2.id_valid}, 32'h0);

    // Streaming with decode always ready
    bus.fetch_en = 1'b1; bus.id_ready = 1'b1; reset = 1'b0;
    cycle(); chk("s_pc0", bus.id_pc, 32'h0); chk("s_in0", bus.id_instr, 32'h0000_0013);
    chk("wrap_pc0", bus2.id_pc, 32'hFFFF_FFFC);
    cycle(); chk("s_pc1", bus.id_pc, 32'h4); chk("s_in1", bus.id_instr, 32'h0010_0093);
    chk("wrap_pc1", bus2.id_pc, 32'h0);
    cycle(); chk("s_pc2", bus.id_pc, 32'h8); chk("s_in2", bus.id_instr, 32'h0020_0113);
    cycle(); chk("s_pc3", bus.id_pc, 32'hC); chk("s_in3", bus.id_instr, 32'h0030_8193);

    // Backpressure: buffer fills, PC stalls, then drains without duplicates
    reset = 1'b1; bus.id_ready = 1'b0;
    cycle(); reset = 1'b0;
    repeat (5) cycle();
    chk("bp_addr", bus.imem_addr, 32'h8); chk("bp_head", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1;
    cycle(); chk("bp_rel1", bus.id_pc, 32'h4);
    cycle(); chk("bp_rel2", bus.id_pc, 32'h8);

    // Redirect with full buffer and same-cycle pop
    bus.id_ready = 1'b0;
    cycle(); cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4; bus.id_ready = 1'b1;
    cycle(); chk("rd_valid", {31'b0, bus.id_valid}, 32'h0); chk("rd_addr", bus.imem_addr, 32'h4);
    bus.redirect_valid = 1'b0;
    cycle(); chk("rd_pc", bus.id_pc, 32'h4); chk("rd_in", bus.id_instr, 32'h0010_0093);

    // Misaligned redirect, then recovery
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
    cycle(); chk("ma_fault", {31'b0, bus.misalign_fault}, 32'h1); chk("ma_addr", bus.imem_addr, 32'h6);
    bus.redirect_valid = 1'b0;
    repeat (4) begin
      cycle(); chk("ma_idle", {31'b0, bus.id_valid}, 32'h0); chk("ma_addr_hold", bus.imem_addr, 32'h6);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    cycle(); chk("ma_clear", {31'b0, bus.misalign_fault}, 32'h0);
    bus.redirect_valid = 1'b0;
    cycle(); chk("ma_rec_pc", bus.id_pc, 32'h0); chk("ma_rec_in", bus.id_instr, 32'h0000_0013);

    // PC wrap at top of address space
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    cycle(); bus.redirect_valid = 1'b0;
    cycle(); chk("wr_top", bus.id_pc, 32'hFFFF_FFFC);
    cycle(); chk("wr_zero", bus.id_pc, 32'h0);

    // Asynchronous reset mid-stream
    reset = 1'b1; #1;
    model_reset();
    chk("arst_valid", {31'b0, bus.id_valid}, 32'h0); chk("arst_addr", bus.imem_addr, 32'h0);
    check_model();
    cycle(); reset = 1'b0;
    cycle(); cycle();

    // Reset beats a simultaneous redirect
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    cycle(); chk("rr_addr", bus.imem_addr, 32'h0);
    reset = 1'b0; bus.redirect_valid = 1'b0;
    cycle(); chk("rr_pc", bus.id_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.fetch_en       = ($urandom_range(0, 9) < 8);
      bus.id_ready       = ($urandom_range(0, 9) < 6);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = tgts[$urandom_range(0, 7)];
      cycle();
    end
    bus.redirect_valid = 1'b0; bus.fetch_en = 1'b1; bus.id_ready = 1'b1;

`ifdef FETCH_HALT_ON_EBREAK_EN
    ebreak_at_8 = 1'b1; reset = 1'b1;
    cycle(); reset = 1'b0;
    cycle(); chk("eb_pc0", bus.id_pc, 32'h0);
    cycle(); chk("eb_pc1", bus.id_pc, 32'h4);
    cycle(); chk("eb_pc2", bus.id_pc, 32'h8); chk("eb_halt", {31'b0, bus.halted}, 32'h1);
    cycle(); chk("eb_addr", bus.imem_addr, 32'h8); chk("eb_drained", {31'b0, bus.id_valid}, 32'h0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    cycle(); chk("eb_resume", {31'b0, bus.halted}, 32'h0);
    bus.redirect_valid = 1'b0;
    cycle(); chk("eb_res_pc", bus.id_pc, 32'h0);
    ebreak_at_8 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
